// File: rtl/cam_op_scheduler.sv
// Single-outstanding scheduler between read/write/search requesters and the CAM core.
// Fixed priority read > write > search, with aging promotion and a WAIT timeout.
module cam_op_scheduler #(
   parameter int WIDTH        = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int TIMEOUT      = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  rd_req_i,
   input  logic [ADDR_WIDTH-1:0] rd_index_i,
   output logic                  rd_gnt_o,
   input  logic                  wr_req_i,
   input  logic [ADDR_WIDTH-1:0] wr_index_i,
   input  logic [WIDTH-1:0]      wr_data_i,
   output logic                  wr_gnt_o,
   input  logic                  srch_req_i,
   input  logic [WIDTH-1:0]      srch_data_i,
   output logic                  srch_gnt_o,
   output logic                  cam_read_enable_o,
   output logic                  cam_write_enable_o,
   output logic                  cam_search_enable_o,
   output logic [ADDR_WIDTH-1:0] cam_index_o,
   output logic [WIDTH-1:0]      cam_data_o,
   input  logic                  cam_done_i,
   input  logic [WIDTH-1:0]      cam_data_i,
   input  logic                  cam_hit_i,
   input  logic [ADDR_WIDTH-1:0] cam_hit_index_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [1:0]            resp_op_o,
   output logic [WIDTH-1:0]      resp_data_o,
   output logic                  resp_hit_o,
   output logic [ADDR_WIDTH-1:0] resp_index_o,
   output logic                  resp_err_o
);

   localparam int AGW = $clog2(STARVE_LIMIT + 1);
   localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [AGW-1:0] AGE_MAX   = AGW'(STARVE_LIMIT);
   localparam logic [CW-1:0]  WAIT_LAST = CW'(TIMEOUT - 1);
   localparam logic [1:0] OP_RD = 2'b01;
   localparam logic [1:0] OP_WR = 2'b10;
   localparam logic [1:0] OP_SR = 2'b11;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

   state_t                state_q, state_d;
   logic                  rst_meta_q, rst_sync_q;
   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [WIDTH-1:0]      data_q;
   logic [CW-1:0]         wait_cnt_q;
   logic [AGW-1:0]        wr_age_q, srch_age_q;
   logic [WIDTH-1:0]      resp_data_q;
   logic                  resp_hit_q, resp_err_q;
   logic [ADDR_WIDTH-1:0] resp_index_q;
   logic                  sel_rd_s, sel_wr_s, sel_sr_s, any_sel_s;

   // Reset synchronizer: assertion is immediate, release aligns to clk_i
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   // Arbitration: starved write, then starved search, then fixed priority
   always_comb begin
      sel_rd_s = 1'b0;
      sel_wr_s = 1'b0;
      sel_sr_s = 1'b0;
      if (state_q == S_IDLE && rst_sync_q) begin
         if (wr_req_i && wr_age_q == AGE_MAX) sel_wr_s = 1'b1;
         else if (srch_req_i && srch_age_q == AGE_MAX) sel_sr_s = 1'b1;
         else if (rd_req_i) sel_rd_s = 1'b1;
         else if (wr_req_i) sel_wr_s = 1'b1;
         else if (srch_req_i) sel_sr_s = 1'b1;
         else sel_rd_s = 1'b0;
      end else begin
         sel_rd_s = 1'b0;
      end
      any_sel_s = sel_rd_s | sel_wr_s | sel_sr_s;
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_sync_q) begin
      if (!rst_sync_q) state_q <= S_IDLE;
      else             state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_sel_s) state_d = S_ISSUE; else state_d = S_IDLE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (cam_done_i || wait_cnt_q == WAIT_LAST) state_d = S_RESP; else state_d = S_WAIT;
         S_RESP:  if (resp_ready_i) state_d = S_IDLE; else state_d = S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   // Operation latch, wait counter and response capture
   always_ff @(posedge clk_i or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         op_q         <= 2'b00;
         idx_q        <= '0;
         data_q       <= '0;
         wait_cnt_q   <= '0;
         resp_data_q  <= '0;
         resp_hit_q   <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_index_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (any_sel_s) begin
               op_q   <= sel_rd_s ? OP_RD : (sel_wr_s ? OP_WR : OP_SR);
               idx_q  <= sel_rd_s ? rd_index_i : (sel_wr_s ? wr_index_i : '0);
               data_q <= sel_wr_s ? wr_data_i : (sel_sr_s ? srch_data_i : '0);
            end
            S_ISSUE: wait_cnt_q <= '0;
            S_WAIT: begin
               if (cam_done_i) begin
                  resp_err_q   <= 1'b0;
                  resp_data_q  <= (op_q == OP_RD) ? cam_data_i : data_q;
                  resp_hit_q   <= (op_q == OP_SR) & cam_hit_i;
                  resp_index_q <= (op_q != OP_SR) ? idx_q : (cam_hit_i ? cam_hit_index_i : '0);
               end else if (wait_cnt_q == WAIT_LAST) begin
                  resp_err_q   <= 1'b1;
                  resp_data_q  <= data_q;
                  resp_hit_q   <= 1'b0;
                  resp_index_q <= idx_q;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CW'(1);
               end
            end
            default: wait_cnt_q <= wait_cnt_q;
         endcase
      end
   end

   // Starvation ages: only IDLE cycles count, a dropped request forgets its age
   always_ff @(posedge clk_i or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         wr_age_q   <= '0;
         srch_age_q <= '0;
      end else begin
         if (!wr_req_i || sel_wr_s) wr_age_q <= '0;
         else if (state_q == S_IDLE && wr_age_q != AGE_MAX) wr_age_q <= wr_age_q + AGW'(1);
         else wr_age_q <= wr_age_q;
         if (!srch_req_i || sel_sr_s) srch_age_q <= '0;
         else if (state_q == S_IDLE && srch_age_q != AGE_MAX) srch_age_q <= srch_age_q + AGW'(1);
         else srch_age_q <= srch_age_q;
      end
   end

   // Output decode
   always_comb begin
      rd_gnt_o            = sel_rd_s;
      wr_gnt_o            = sel_wr_s;
      srch_gnt_o          = sel_sr_s;
      cam_read_enable_o   = (state_q == S_ISSUE) && (op_q == OP_RD);
      cam_write_enable_o  = (state_q == S_ISSUE) && (op_q == OP_WR);
      cam_search_enable_o = (state_q == S_ISSUE) && (op_q == OP_SR);
      cam_index_o         = (state_q != S_IDLE) ? idx_q : '0;
      cam_data_o          = (state_q != S_IDLE) ? data_q : '0;
      resp_valid_o        = (state_q == S_RESP);
      resp_op_o           = (state_q == S_RESP) ? op_q : 2'b00;
      resp_data_o         = (state_q == S_RESP) ? resp_data_q : '0;
      resp_hit_o          = (state_q == S_RESP) & resp_hit_q;
      resp_index_o        = (state_q == S_RESP) ? resp_index_q : '0;
      resp_err_o          = (state_q == S_RESP) & resp_err_q;
   end

endmodule

// File: tb/tb_cam_op_scheduler.sv
// Directed bench: expected responses queued at issue time, a monitor compares them
// whenever the scheduler presents a response.
module tb_cam_op_scheduler;
   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        rd_req_i, wr_req_i, srch_req_i;
   logic [4:0]  rd_index_i, wr_index_i;
   logic [31:0] wr_data_i, srch_data_i;
   logic        rd_gnt_o, wr_gnt_o, srch_gnt_o;
   logic        cam_read_enable_o, cam_write_enable_o, cam_search_enable_o;
   logic [4:0]  cam_index_o;
   logic [31:0] cam_data_o;
   logic        cam_done_i = 1'b0;
   logic [31:0] cam_data_i = 32'h0;
   logic        cam_hit_i = 1'b0;
   logic [4:0]  cam_hit_index_i = 5'd0;
   logic        resp_valid_o, resp_ready_i;
   logic [1:0]  resp_op_o;
   logic [31:0] resp_data_o;
   logic        resp_hit_o, resp_err_o;
   logic [4:0]  resp_index_o;

   cam_op_scheduler #(.WIDTH(32), .ADDR_WIDTH(5), .TIMEOUT(16), .STARVE_LIMIT(4)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .rd_req_i(rd_req_i), .rd_index_i(rd_index_i), .rd_gnt_o(rd_gnt_o),
      .wr_req_i(wr_req_i), .wr_index_i(wr_index_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
      .srch_req_i(srch_req_i), .srch_data_i(srch_data_i), .srch_gnt_o(srch_gnt_o),
      .cam_read_enable_o(cam_read_enable_o), .cam_write_enable_o(cam_write_enable_o),
      .cam_search_enable_o(cam_search_enable_o), .cam_index_o(cam_index_o), .cam_data_o(cam_data_o),
      .cam_done_i(cam_done_i), .cam_data_i(cam_data_i), .cam_hit_i(cam_hit_i),
      .cam_hit_index_i(cam_hit_index_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_op_o(resp_op_o),
      .resp_data_o(resp_data_o), .resp_hit_o(resp_hit_o), .resp_index_o(resp_index_o),
      .resp_err_o(resp_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] data;
      logic        hit;
      logic [4:0]  idx;
      logic        err;
   } resp_t;

   resp_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    core_delay = 1;
   logic  core_hit = 1'b0;
   logic [4:0] core_hit_idx = 5'd0;
   logic  force_done = 1'b0;
   int    pend = 0;
   logic [4:0] seen_idx = 5'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic any_out();
      return |{rd_gnt_o, wr_gnt_o, srch_gnt_o, cam_read_enable_o, cam_write_enable_o,
               cam_search_enable_o, cam_index_o, cam_data_o, resp_valid_o, resp_op_o,
               resp_data_o, resp_hit_o, resp_index_o, resp_err_o};
   endfunction

   // Core model: done a fixed number of cycles after the strobe (never if core_delay <= 0)
   always @(negedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pend = 0;
         cam_done_i = 1'b0;
      end else begin
         cam_done_i = force_done;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               cam_done_i      = 1'b1;
               cam_data_i      = 32'hC0DE_0000 | {27'd0, seen_idx};
               cam_hit_i       = core_hit;
               cam_hit_index_i = core_hit_idx;
            end
         end
         if (cam_read_enable_o | cam_write_enable_o | cam_search_enable_o) begin
            seen_idx = cam_index_o;
            pend = (core_delay > 0) ? core_delay : 0;
         end
      end
   end

   // Response monitor: every valid cycle must match the queue head; pop on handshake
   always @(negedge clk_i) begin
      if (reset_n_i) begin
         check("gnt_onehot", 64'($countones({rd_gnt_o, wr_gnt_o, srch_gnt_o}) <= 1), 64'd1);
         if (resp_valid_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp actual op=%0h data=%0h required none", resp_op_o, resp_data_o);
            end else begin
               check("resp_op",    64'(resp_op_o),    64'(exp_q[0].op));
               check("resp_data",  64'(resp_data_o),  64'(exp_q[0].data));
               check("resp_hit",   64'(resp_hit_o),   64'(exp_q[0].hit));
               check("resp_index", 64'(resp_index_o), 64'(exp_q[0].idx));
               check("resp_err",   64'(resp_err_o),   64'(exp_q[0].err));
               if (resp_ready_i) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic wait_gnt(input string name, output logic [2:0] g);
      g = 3'b000;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_i);
         if (rd_gnt_o | wr_gnt_o | srch_gnt_o) begin
            g = {rd_gnt_o, wr_gnt_o, srch_gnt_o};
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL %s actual=no_grant required=grant", name);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 80; i++) begin
         if (exp_q.size() == 0) return;
         @(negedge clk_i);
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   logic [2:0] g;
   logic [2:0] order [11];
   int cnt;

   initial begin
      reset_n_i = 1'b0;
      rd_req_i = 1'b0; wr_req_i = 1'b0; srch_req_i = 1'b0;
      rd_index_i = 5'd0; wr_index_i = 5'd0; wr_data_i = 32'h0; srch_data_i = 32'h0;
      resp_ready_i = 1'b1;
      #23 reset_n_i = 1'b1;

      // idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         check("reset_idle_outs", 64'(any_out()), 64'd0);
      end

      // write, done after one cycle
      @(posedge clk_i); #1;
      wr_req_i = 1'b1; wr_index_i = 5'd3; wr_data_i = 32'hDEAD_BEEF;
      exp_q.push_back('{op: 2'b10, data: 32'hDEAD_BEEF, hit: 1'b0, idx: 5'd3, err: 1'b0});
      @(negedge clk_i);
      check("wr_gnt_N", 64'(wr_gnt_o), 64'd1);
      @(posedge clk_i); #1 wr_req_i = 1'b0;
      @(negedge clk_i);
      check("wr_strobe_N1", 64'({cam_write_enable_o, cam_read_enable_o, cam_search_enable_o, wr_gnt_o}), 64'b1000);
      check("wr_cam_index", 64'(cam_index_o), 64'd3);
      check("wr_cam_data", 64'(cam_data_o), 64'hDEAD_BEEF);
      @(negedge clk_i);
      check("wr_N2", 64'({cam_write_enable_o, resp_valid_o}), 64'b00);
      @(negedge clk_i);
      check("wr_resp_N3", 64'(resp_valid_o), 64'd1);
      wait_drain("wr_drain");

      // search with hit, response held while ready is low and a read waits
      core_hit = 1'b1; core_hit_idx = 5'd3; resp_ready_i = 1'b0;
      @(posedge clk_i); #1;
      srch_req_i = 1'b1; srch_data_i = 32'hDEAD_BEEF;
      exp_q.push_back('{op: 2'b11, data: 32'hDEAD_BEEF, hit: 1'b1, idx: 5'd3, err: 1'b0});
      @(negedge clk_i);
      check("srch_gnt", 64'(srch_gnt_o), 64'd1);
      @(posedge clk_i); #1;
      srch_req_i = 1'b0; rd_req_i = 1'b1; rd_index_i = 5'd4;
      exp_q.push_back('{op: 2'b01, data: 32'hC0DE_0004, hit: 1'b0, idx: 5'd4, err: 1'b0});
      cnt = 0;
      for (int i = 0; i < 10 && !resp_valid_o; i++) @(negedge clk_i);
      check("srch_resp_arrives", 64'(resp_valid_o), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         check("hold_no_gnt", 64'({resp_valid_o, rd_gnt_o}), 64'b10);
      end
      @(posedge clk_i); #1 resp_ready_i = 1'b1;
      wait_gnt("rd_after_hold", g);
      check("rd_after_hold_gnt", 64'(g), 64'b100);
      @(posedge clk_i); #1 rd_req_i = 1'b0;
      wait_drain("srch_rd_drain");

      // read that times out; a late done must not produce a second response
      core_delay = 0;
      @(posedge clk_i); #1;
      rd_req_i = 1'b1; rd_index_i = 5'd7;
      exp_q.push_back('{op: 2'b01, data: 32'h0, hit: 1'b0, idx: 5'd7, err: 1'b1});
      wait_gnt("to_gnt", g);
      @(posedge clk_i); #1 rd_req_i = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         cnt++;
         if (resp_valid_o) break;
      end
      check("timeout_latency", 64'(cnt), 64'd18);
      @(posedge clk_i); #1 force_done = 1'b1;
      @(posedge clk_i); #1 force_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         check("late_done_ignored", 64'(resp_valid_o), 64'd0);
      end
      wait_drain("to_drain");

      // all three requesters held: aging pattern
      core_delay = 1; core_hit = 1'b1; core_hit_idx = 5'd9;
      order = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100, 3'b100, 3'b100, 3'b010, 3'b001};
      @(posedge clk_i); #1;
      rd_req_i = 1'b1; rd_index_i = 5'd2;
      wr_req_i = 1'b1; wr_index_i = 5'd5; wr_data_i = 32'h1111_2222;
      srch_req_i = 1'b1; srch_data_i = 32'h3333_4444;
      for (int k = 0; k < 11; k++) begin
         if (order[k] == 3'b100)
            exp_q.push_back('{op: 2'b01, data: 32'hC0DE_0002, hit: 1'b0, idx: 5'd2, err: 1'b0});
         else if (order[k] == 3'b010)
            exp_q.push_back('{op: 2'b10, data: 32'h1111_2222, hit: 1'b0, idx: 5'd5, err: 1'b0});
         else
            exp_q.push_back('{op: 2'b11, data: 32'h3333_4444, hit: 1'b1, idx: 5'd9, err: 1'b0});
      end
      for (int k = 0; k < 11; k++) begin
         wait_gnt("age_gnt", g);
         check("age_grant_order", 64'(g), 64'(order[k]));
      end
      @(posedge clk_i); #1;
      rd_req_i = 1'b0; wr_req_i = 1'b0; srch_req_i = 1'b0;
      wait_drain("age_drain");

      // write withdrawn while a read is served
      @(posedge clk_i); #1;
      rd_req_i = 1'b1; rd_index_i = 5'd1;
      wr_req_i = 1'b1; wr_index_i = 5'd6; wr_data_i = 32'h5;
      exp_q.push_back('{op: 2'b01, data: 32'hC0DE_0001, hit: 1'b0, idx: 5'd1, err: 1'b0});
      @(negedge clk_i);
      check("drop_rd_first", 64'({rd_gnt_o, wr_gnt_o}), 64'b10);
      @(posedge clk_i); #1;
      rd_req_i = 1'b0; wr_req_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         check("drop_no_write", 64'({cam_write_enable_o, wr_gnt_o}), 64'b00);
      end
      wait_drain("drop_drain");

      // reset asserted during WAIT
      core_delay = 0;
      @(posedge clk_i); #1;
      rd_req_i = 1'b1; rd_index_i = 5'd8;
      wait_gnt("rst_gnt", g);
      @(posedge clk_i); #1 rd_req_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      @(negedge clk_i);
      check("rst_pre_cam_index", 64'(cam_index_o), 64'd8);
      #2 reset_n_i = 1'b0;
      #1 check("rst_async_outs", 64'(any_out()), 64'd0);
      @(posedge clk_i); #3 reset_n_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         check("rst_no_replay", 64'(any_out()), 64'd0);
      end

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end
endmodule

// File: doc/cam_op_scheduler.md
Name: cam_op_scheduler

Overview:
- Sequential front end for the CAM core. It arbitrates read, write and search requesters onto the core's enable/index/data interface.
- Allows one outstanding operation at a time. Waits for core completion with a timeout, then returns a held response to the requesters.
- Fixed priority read > write > search. Aging prevents write and search starvation.

Parameters:
- WIDTH, 32, data/key width
- ADDR_WIDTH, 5, entry index width
- TIMEOUT, 16, max WAIT cycles before error response (>=2)
- STARVE_LIMIT, 4, pending-but-ungranted cycles before a write/search is promoted (>=1)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- rd_req_i  in  1  read request, held until granted
- rd_index_i  in  ADDR_WIDTH  read entry index
- rd_gnt_o  out  1  read granted; operands sampled this edge
- wr_req_i  in  1  write request
- wr_index_i  in  ADDR_WIDTH  write entry index
- wr_data_i  in  WIDTH  write data
- wr_gnt_o  out  1  write granted
- srch_req_i  in  1  search request
- srch_data_i  in  WIDTH  search key
- srch_gnt_o  out  1  search granted
- cam_read_enable_o  out  1  core read strobe
- cam_write_enable_o  out  1  core write strobe
- cam_search_enable_o  out  1  core search strobe
- cam_index_o  out  ADDR_WIDTH  core index
- cam_data_o  out  WIDTH  core write data/search key
- cam_done_i  in  1  core completion pulse
- cam_data_i  in  WIDTH  core read data
- cam_hit_i  in  1  core search hit
- cam_hit_index_i  in  ADDR_WIDTH  core matching index
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response accepted
- resp_op_o  out  2  01 read, 10 write, 11 search
- resp_data_o  out  WIDTH  read data (read), written data (write), key (search)
- resp_hit_o  out  1  search hit; 0 for read/write
- resp_index_o  out  ADDR_WIDTH  accessed index, or hit index for search
- resp_err_o  out  1  timeout occurred

Behaviour:
- Reset (async assert, sync deassert on clk_i): state=IDLE. All outputs 0. Age counters 0. Wait counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, selection order:
  - Write if write age == STARVE_LIMIT.
  - Else search if search age == STARVE_LIMIT.
  - Else read > write > search.
  - The selected gnt_o is asserted combinationally in the same cycle, only in IDLE, at most one gnt high.
  - At the edge: latch op/index/data, go to ISSUE. No request pending: stay in IDLE.
- ISSUE: exactly one cam_*_enable_o high for exactly 1 cycle, with latched cam_index_o/cam_data_o. Go to WAIT with the wait counter cleared.
- cam_index_o/cam_data_o: hold the latched values from ISSUE through RESP. Otherwise 0.
- WAIT:
  - cam_done_i=1 captures cam_data_i/cam_hit_i/cam_hit_index_i per op and goes to RESP with err=0.
  - Otherwise the counter increments. At count TIMEOUT-1 without done, go to RESP with err=1, hit=0, data=latched data.
  - cam_done_i is ignored in IDLE/ISSUE/RESP. A late done after a timeout is dropped.
- RESP: resp_valid_o=1 with all resp_* stable until the cycle resp_ready_i=1. That edge returns to IDLE and resp_valid_o drops. The new arbitration happens in the following IDLE cycle.
- Latency: gnt at cycle N, strobe at N+1, earliest done at N+2, resp_valid_o at N+3. Back-to-back ops are separated by at least 1 IDLE cycle.
- Aging:
  - Write/search age increments (saturating at STARVE_LIMIT) in each IDLE cycle where its req=1 and it is not granted.
  - Age clears on grant or when req=0.
  - Non-IDLE cycles do not age.
- Requesters must hold req and operands stable until gnt. Dropping req before gnt is legal; that request is not served.
- Reset mid-operation: returns to IDLE immediately. Any strobe/response is abandoned with no replay.

Test Plan:
- Reset, all req=0 -> all outputs 0, state IDLE for 10 cycles. Assert reset_n_i=0 during WAIT -> outputs 0 asynchronously.
- Write req idx=3 data=0xDEADBEEF, done after 1 cycle -> wr_gnt_o 1 cycle, cam_write_enable_o 1 cycle with index 3. resp_op_o=10, resp_data_o=0xDEADBEEF, err=0 at N+3.
- Search key 0xDEADBEEF, core returns hit=1 idx=3 -> resp_op_o=11, hit=1, index=3. Hold resp_ready_i=0 for 5 cycles -> response stable, no new grant.
- Read idx=7 with core never asserting done, TIMEOUT=16 -> resp_err_o=1 after 16 WAIT cycles. A late done is ignored and causes no second response.
- rd/wr/srch all held continuously, core done in 1 cycle, STARVE_LIMIT=4 -> reads win until write age reaches 4, then write granted. Search is granted within a bounded number of ops. Never more than one gnt per cycle.
- wr_req_i dropped before grant while read busy -> no write strobe, write age returns to 0.
